layer45_trainer: RTL and testbench

LAYER45_TRAINER -- requirements
Module: layer45_trainer

---
 rtl/layer45_trainer_if.sv | 41 ++++
 rtl/layer45_trainer.sv | 127 ++++++++++++
 tb/tb_layer45_trainer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer45_trainer_if.sv
// rtl/layer45_trainer_if.sv - sample, layer and result buses of the layer trainer
// zero2one_t is carried as a W-bit unsigned fraction, all-ones meaning 1.0.
interface layer45_trainer_if #(
  parameter int N = 16,
  parameter int M = 45,
  parameter int W = 8
);
  localparam int EW = $clog2(M + 1);

  logic                s_valid;
  logic                s_ready;
  logic                s_train;
  logic [N-1:0][W-1:0] s_in;
  logic [M-1:0][W-1:0] s_expected;

  logic                l_valid;
  logic                l_learn;
  logic [N-1:0][W-1:0] l_in;
  logic [M-1:0][W-1:0] l_expected_out;
  logic [M-1:0][W-1:0] l_out;

  logic                r_valid;
  logic                r_ready;
  logic [M-1:0][W-1:0] r_out;
  logic [EW-1:0]       r_err;

  logic [15:0]         sample_count;
  logic [15:0]         train_count;

  modport master (
    input  s_valid, s_train, s_in, s_expected, l_out, r_ready,
    output s_ready, l_valid, l_learn, l_in, l_expected_out,
           r_valid, r_out, r_err, sample_count, train_count
  );

  modport slave (
    output s_valid, s_train, s_in, s_expected, l_out, r_ready,
    input  s_ready, l_valid, l_learn, l_in, l_expected_out,
           r_valid, r_out, r_err, sample_count, train_count
  );
endinterface

// File: rtl/layer45_trainer.sv
// rtl/layer45_trainer.sv - sequences one sample through a neuron layer
// Presents the sample, waits SETTLE cycles, captures output and error count, optionally learns.
module layer45_trainer #(
  parameter int             N      = 16,
  parameter int             M      = 45,
  parameter int             SETTLE = 2,
  parameter int             W      = 8,
  parameter logic [W-1:0]   TOL    = '0
) (
  input  logic clock,
  input  logic reset_n,
  layer45_trainer_if.master bus
);
  localparam int         EW          = $clog2(M + 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_SETTLE,
    S_LEARN,
    S_RESULT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_settle_cnt;
  logic [N-1:0][W-1:0] r_l_in;
  logic [M-1:0][W-1:0] r_l_exp;
  logic                r_train;
  logic [M-1:0][W-1:0] r_cap_out;
  logic [EW-1:0]       r_cap_err;
  logic [15:0]         r_sample_cnt;
  logic [15:0]         r_train_cnt;

  logic                w_accept;
  logic                w_release;
  logic                w_settle_done;
  logic [EW-1:0]       w_err_cnt;

  assign w_accept      = bus.s_valid && (r_state == S_IDLE);
  assign w_release     = bus.r_ready && (r_state == S_RESULT);
  assign w_settle_done = (r_state == S_SETTLE) && (r_settle_cnt == SETTLE_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_PRESENT;
      S_PRESENT: w_next = S_SETTLE;
      S_SETTLE:  if (w_settle_done) w_next = r_train ? S_LEARN : S_RESULT;
      S_LEARN:   w_next = S_RESULT;
      S_RESULT:  if (w_release) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = (r_state == S_IDLE);
    bus.l_valid = (r_state == S_PRESENT) || (r_state == S_LEARN);
    bus.l_learn = (r_state == S_LEARN);
    bus.r_valid = (r_state == S_RESULT);
  end

  // Distance is taken as larger-minus-smaller so it never wraps in W bits.
  always_comb begin : p_err
    logic [W-1:0] w_d;
    w_d       = '0;
    w_err_cnt = '0;
    for (int i = 0; i < M; i++) begin
      if (bus.l_out[i] > r_l_exp[i]) begin
        w_d = bus.l_out[i] - r_l_exp[i];
      end else begin
        w_d = r_l_exp[i] - bus.l_out[i];
      end
      if (w_d > TOL) begin
        w_err_cnt = w_err_cnt + EW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_settle_cnt <= '0;
      r_l_in       <= '0;
      r_l_exp      <= '0;
      r_train      <= 1'b0;
      r_cap_out    <= '0;
      r_cap_err    <= '0;
      r_sample_cnt <= '0;
      r_train_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_l_in  <= bus.s_in;
        r_l_exp <= bus.s_expected;
        r_train <= bus.s_train;
      end
      if (r_state == S_SETTLE) begin
        r_settle_cnt <= w_settle_done ? 4'd0 : r_settle_cnt + 4'd1;
      end
      if (w_settle_done) begin
        r_cap_out <= bus.l_out;
        r_cap_err <= w_err_cnt;
      end
      if (r_state == S_LEARN) begin
        r_train_cnt <= r_train_cnt + 16'd1;
      end
      if (w_release) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
    end
  end

  assign bus.l_in           = r_l_in;
  assign bus.l_expected_out = r_l_exp;
  assign bus.r_out          = r_cap_out;
  assign bus.r_err          = r_cap_err;
  assign bus.sample_count   = r_sample_cnt;
  assign bus.train_count    = r_train_cnt;
endmodule

// File: tb/tb_layer45_trainer.sv
// tb/tb_layer45_trainer.sv - randomized bench for layer45_trainer against a sample-level model
// The bench plays both the sample source and a layer that answers one cycle after l_valid.
module tb_layer45_trainer;
  localparam int           N      = 16;
  localparam int           M      = 45;
  localparam int           W      = 8;
  localparam int           SETTLE = 2;
  localparam logic [W-1:0] TOL    = 8'd3;
  localparam int           ZMAX   = 255;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_samples = 0;
  int   exp_trains  = 0;

  always #5 clock = ~clock;

  layer45_trainer_if #(.N(N), .M(M), .W(W)) bus ();

  layer45_trainer #(
    .N(N), .M(M), .SETTLE(SETTLE), .W(W), .TOL(TOL)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_vecs(output logic [N-1:0][W-1:0] a, output logic [M-1:0][W-1:0] b);
    for (int i = 0; i < N; i++) a[i] = W'($urandom);
    for (int i = 0; i < M; i++) b[i] = W'($urandom);
  endtask

  // mode 0: random distances around TOL, 1: layer matches, 2: only output 3 is ZMAX vs 0, 3: all far
  task automatic run_sample(input bit train, input int mode, input int hold);
    logic [N-1:0][W-1:0] in_v, junk_in;
    logic [M-1:0][W-1:0] exp_v, resp, junk_out;
    int e, d, r, diff, want_err, cyc, lv, ll, first_lv, w;
    bit got;
    rand_vecs(in_v, exp_v);
    if (mode == 2) exp_v[3] = '0;
    want_err = 0;
    for (int i = 0; i < M; i++) begin
      e = int'(exp_v[i]);
      case (mode)
        0: case ($urandom_range(0, 3))
             0: d = 0;
             1: d = int'(TOL);
             2: d = int'(TOL) + 1;
             default: d = $urandom_range(0, ZMAX);
           endcase
        2: d = (i == 3) ? ZMAX : 0;
        3: d = 128;
        default: d = 0;
      endcase
      if (e + d <= ZMAX) r = e + d;
      else if (e - d >= 0) r = e - d;
      else r = ZMAX;
      resp[i] = W'(r);
      diff = (r > e) ? r - e : e - r;
      if (diff > int'(TOL)) want_err++;
    end

    @(negedge clock);
    rand_vecs(junk_in, junk_out);
    bus.s_in       = in_v;
    bus.s_expected = exp_v;
    bus.s_train    = train;
    bus.s_valid    = 1'b1;
    bus.l_out      = junk_out;
    w = 0;
    while (!bus.s_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("accept_wait", 512'(w < 20), 512'(1));

    cyc = 0; lv = 0; ll = 0; first_lv = -1; got = 0;
    while (cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        bus.s_valid = 1'b0;
        rand_vecs(junk_in, junk_out);
        bus.s_in       = junk_in;
        bus.s_expected = junk_out;
        bus.s_train    = ~train;
      end
      if (bus.r_valid) begin
        got = 1;
        break;
      end
      chk("s_ready_busy", 512'(bus.s_ready), 512'(0));
      if (bus.l_valid) begin
        lv++;
        if (first_lv < 0) first_lv = cyc;
        chk("l_in", 512'(bus.l_in), 512'(in_v));
        if (!bus.l_learn) bus.l_out = resp;
      end
      if (bus.l_learn) begin
        ll++;
        chk("learn_cycle", 512'(cyc), 512'(SETTLE + 2));
        chk("l_expected_out", 512'(bus.l_expected_out), 512'(exp_v));
      end
    end
    chk("got_r_valid", 512'(got), 512'(1));
    chk("latency", 512'(cyc), 512'(train ? SETTLE + 3 : SETTLE + 2));
    chk("first_l_valid", 512'(first_lv), 512'(1));
    chk("l_valid_pulses", 512'(lv), 512'(train ? 2 : 1));
    chk("l_learn_pulses", 512'(ll), 512'(train));
    chk("r_out", 512'(bus.r_out), 512'(resp));
    chk("r_err", 512'(bus.r_err), 512'(want_err));

    rand_vecs(junk_in, junk_out);
    bus.l_out = junk_out;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      chk("hold_r_valid", 512'(bus.r_valid), 512'(1));
      chk("hold_r_out", 512'(bus.r_out), 512'(resp));
      chk("hold_r_err", 512'(bus.r_err), 512'(want_err));
      chk("hold_s_ready", 512'(bus.s_ready), 512'(0));
    end
    bus.r_ready = 1'b1;
    @(negedge clock);
    bus.r_ready = 1'b0;
    exp_samples = (exp_samples + 1) % 65536;
    if (train) exp_trains = (exp_trains + 1) % 65536;
    chk("done_r_valid", 512'(bus.r_valid), 512'(0));
    chk("done_s_ready", 512'(bus.s_ready), 512'(1));
    chk("sample_count", 512'(bus.sample_count), 512'(exp_samples));
    chk("train_count", 512'(bus.train_count), 512'(exp_trains));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, 512'(bus.s_ready), 512'(1));
    chk({tag, "_l_valid"}, 512'(bus.l_valid), 512'(0));
    chk({tag, "_l_learn"}, 512'(bus.l_learn), 512'(0));
    chk({tag, "_r_valid"}, 512'(bus.r_valid), 512'(0));
    chk({tag, "_r_err"}, 512'(bus.r_err), 512'(0));
    chk({tag, "_r_out"}, 512'(bus.r_out), 512'(0));
    chk({tag, "_l_in"}, 512'(bus.l_in), 512'(0));
    chk({tag, "_l_exp"}, 512'(bus.l_expected_out), 512'(0));
    chk({tag, "_sample_count"}, 512'(bus.sample_count), 512'(0));
    chk({tag, "_train_count"}, 512'(bus.train_count), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][W-1:0] a;
    logic [M-1:0][W-1:0] b;
    int w;
    bus.s_valid    = 1'b0;
    bus.s_train    = 1'b0;
    bus.s_in       = '0;
    bus.s_expected = '0;
    bus.l_out      = '0;
    bus.r_ready    = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("por");
    reset_n = 1'b1;

    run_sample(1'b0, 1, 0);
    run_sample(1'b1, 2, 0);
    run_sample(1'b0, 0, 10);
    for (int n = 0; n < 30; n++) begin
      run_sample(1'($urandom_range(0, 1)), 0, $urandom_range(0, 3));
    end
    run_sample(1'b0, 3, 1);
    run_sample(1'b1, 3, 2);

    @(negedge clock);
    rand_vecs(a, b);
    bus.s_in       = a;
    bus.s_expected = b;
    bus.s_valid    = 1'b1;
    reset_n        = 1'b0;
    @(negedge clock);
    bus.s_valid = 1'b0;
    reset_n     = 1'b1;
    exp_samples = 0;
    exp_trains  = 0;
    check_reset_state("rst_vs_accept");

    run_sample(1'b1, 0, 0);
    @(negedge clock);
    rand_vecs(a, b);
    bus.s_in       = a;
    bus.s_expected = b;
    bus.s_train    = 1'b1;
    bus.s_valid    = 1'b1;
    w = 0;
    while (!bus.l_learn && w < 20) begin
      @(negedge clock);
      if (bus.l_valid) bus.s_valid = 1'b0;
      w++;
    end
    chk("reach_learn", 512'(bus.l_learn), 512'(1));
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_samples = 0;
    exp_trains  = 0;
    check_reset_state("rst_in_learn");
    @(negedge clock);
    chk("post_rst_idle", 512'(bus.s_ready), 512'(1));

    run_sample(1'b0, 0, 1);
    run_sample(1'b1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
